ntlm_candidate_gen: RTL

- Producer end of the hash core's password interface. Enumerates brute-force password candidates and drives `instr`/`length` into the combinational NTLM hash calculator.
- Compares the returned 128-bit hash against a target and stops on a match or when the search space is exhausted.
- Evaluates one candidate per clock. Sits between the control/host interface and the hash core in the cracker top level.

---
 rtl/ntlm_candidate_gen_pkg.sv | 39 +++
 rtl/ntlm_candidate_gen_char_map.sv | 28 ++
 rtl/ntlm_candidate_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ntlm_candidate_gen_pkg.sv
// ntlm_pkg
// Shared definitions for the NTLM candidate generator: the search state
// encoding, default search-space dimensions, the ASCII bases used to turn
// a character index into a printable byte, and the index-to-ASCII helper.
//
// No ports (package).
package ntlm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_FOUND     = 2'd2,
        ST_EXHAUSTED = 2'd3
    } state_t;

    localparam int DEFAULT_MAX_LEN      = 8;
    localparam int DEFAULT_CHARSET_SIZE = 36;

    // Indices below LETTER_COUNT are lower-case letters, the rest are digits.
    localparam int LETTER_COUNT = 26;

    localparam int IDX_W = $clog2(DEFAULT_CHARSET_SIZE);

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_DIGIT_0 = 8'h30;

    // Maps a character index to its ASCII byte: 0..25 -> 'a'..'z',
    // 26..35 -> '0'..'9'.
    function automatic logic [7:0] idx_to_ascii(input logic [7:0] idx);
        logic [7:0] result;
        if (idx < 8'(LETTER_COUNT)) begin
            result = ASCII_LOWER_A + idx;
        end else begin
            result = ASCII_DIGIT_0 + (idx - 8'(LETTER_COUNT));
        end
        return result;
    endfunction

endpackage

// File: rtl/ntlm_candidate_gen_char_map.sv
// char_map
// Combinational lookup from one character-position index to its ASCII byte.
// Inactive positions (beyond the current candidate length) emit 8'h00 so
// the assembled string is zero-padded.
//
// Ports:
//   idx    in  W   character index (0..CHARSET_SIZE-1)
//   active in  1   position lies inside the current candidate
//   ascii  out 8   ASCII byte for this position, or 0 when inactive
module char_map
    import ntlm_pkg::*;
#(
    parameter int W = IDX_W
) (
    input  logic [W-1:0] idx,
    input  logic         active,
    output logic [7:0]   ascii
);

    // Inactive positions must read as zero regardless of the stored index.
    always_comb begin
        ascii = 8'h00;
        if (active) begin
            ascii = idx_to_ascii(8'(idx));
        end
    end

endmodule

// File: rtl/ntlm_candidate_gen.sv
// ntlm_candidate_gen
// Brute-force password candidate enumerator feeding a combinational NTLM
// hash core. One candidate is presented per clock on instr/length; the hash
// core answers in the same cycle on hash_in, and the result is compared
// against the latched target on the closing edge. The search stops on a
// match (FOUND) or after the last candidate of the space (EXHAUSTED).
//
// Ports:
//   clk            in   1      system clock
//   n_rst          in   1      asynchronous active-low reset
//   start          in   1      pulse: begin a new search (ignored while running)
//   abort          in   1      pulse: stop and return to idle (beats start)
//   target_hash    in   128    hash to crack, latched on start
//   hash_in        in   128    hash core result for the current candidate
//   instr          out  128    candidate string, character k in byte k
//   length         out  4      candidate length in characters
//   busy           out  1      search in progress
//   found          out  1      instr/length hold the matching password
//   done           out  1      search ended (match or exhaustion)
//   attempt_count  out  CNT_W  candidates compared since start, saturating
module ntlm_candidate_gen
    import ntlm_pkg::*;
#(
    parameter int MAX_LEN      = DEFAULT_MAX_LEN,
    parameter int CHARSET_SIZE = DEFAULT_CHARSET_SIZE,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [127:0]     target_hash,
    input  logic [127:0]     hash_in,
    output logic [127:0]     instr,
    output logic [3:0]       length,
    output logic             busy,
    output logic             found,
    output logic             done,
    output logic [CNT_W-1:0] attempt_count
);

    localparam int            CW        = $clog2(CHARSET_SIZE);
    localparam logic [CW-1:0] LAST_IDX  = CW'(CHARSET_SIZE - 1);
    localparam logic [3:0]    LEN_LIMIT = 4'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q [MAX_LEN];
    logic [CW-1:0]    idx_d [MAX_LEN];
    logic [3:0]       len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     target_q, target_d;
    logic             all_max;
    logic             carry;
    logic [MAX_LEN-1:0] pos_active;

    // Registers for the FSM state and every piece of datapath state. Reset
    // clears everything, including the latched target, so nothing from an
    // interrupted search survives.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '{default: '0};
            len_q    <= 4'd0;
            cnt_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    // Next-state and datapath update. Everything holds by default; abort
    // overrides all other activity and returns to idle with the string
    // cleared but the attempt counter preserved.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        all_max  = 1'b1;
        carry    = 1'b1;

        // The candidate is the last one of its length when every active
        // position sits on the final symbol.
        for (int p = 0; p < MAX_LEN; p++) begin
            if ((4'(p) < len_q) && (idx_q[p] != LAST_IDX)) begin
                all_max = 1'b0;
            end
        end

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '{default: '0};
            len_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (start) begin
                        target_d = target_hash;
                        idx_d    = '{default: '0};
                        len_d    = 4'd1;
                        cnt_d    = '0;
                        state_d  = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end

                    // A match is checked first so that a hit on the very
                    // last candidate is still reported as found.
                    if (hash_in == target_q) begin
                        state_d = ST_FOUND;
                    end else if (all_max && (len_q == LEN_LIMIT)) begin
                        state_d = ST_EXHAUSTED;
                    end else if (all_max) begin
                        len_d = len_q + 4'd1;
                        idx_d = '{default: '0};
                    end else begin
                        // Odometer step: position len-1 is least
                        // significant, so walk from the top index down and
                        // only touch positions inside the current length.
                        for (int p = MAX_LEN - 1; p >= 0; p--) begin
                            if ((4'(p) < len_q) && carry) begin
                                if (idx_q[p] == LAST_IDX) begin
                                    idx_d[p] = '0;
                                end else begin
                                    idx_d[p] = idx_q[p] + CW'(1);
                                    carry    = 1'b0;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Positions at or beyond the current length are masked to zero bytes.
    always_comb begin
        pos_active = '0;
        for (int p = 0; p < MAX_LEN; p++) begin
            pos_active[p] = (4'(p) < len_q);
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_pos
        if (g < MAX_LEN) begin : g_used
            char_map #(
                .W (CW)
            ) u_char_map (
                .idx    (idx_q[g]),
                .active (pos_active[g]),
                .ascii  (instr[8*g +: 8])
            );
        end else begin : g_unused
            assign instr[8*g +: 8] = 8'h00;
        end
    end

    assign length        = len_q;
    assign attempt_count = cnt_q;
    assign busy          = (state_q == ST_RUN);
    assign found         = (state_q == ST_FOUND);
    assign done          = (state_q == ST_FOUND) || (state_q == ST_EXHAUSTED);

endmodule
